pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
- Parametrised elastic pipeline-stage register. It replaces the fixed single-entry latch between pipeline stages (e.g. EX/MEM) with a DEPTH-entry buffer of DATA_W-bit packed stage bundles.
- Adds a valid/ready handshake on both sides, a synchronous flush for branch/jump squash, occupancy reporting and a saturating back-pressure counter.
- Sits between two pipeline stages. The upstream stage packs its control and data fields into in_data; the downstream stage unpacks out_data.

Parameters:
- DATA_W, 32, width of one stage bundle in bits (legal range 1 or more).
- DEPTH, 2, number of buffer entries; power of two, 1 or more.
- CNT_W, 16, width of the back-pressure (stall) counter.

Ports:
- CLK  input  1  rising-edge clock.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream presents a bundle.
- in_ready  output  1  buffer can accept a bundle this cycle.
- in_data  input  DATA_W  upstream bundle.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_data  output  DATA_W  head entry.
- count  output  $clog2(DEPTH+1)  current occupancy.
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- **Reset (nRST low, async):**
  - count, rd_ptr, wr_ptr and stall_cnt are 0.
  - All storage entries are 0.
  - out_valid=0, out_data=0, in_ready=1.
  - Reset mid-transfer discards all contents; there is no partial state.
- **Storage and pointers:**
  - Circular array of DEPTH entries with rd_ptr and wr_ptr of width $clog2(DEPTH), minimum 1 bit.
  - Pointers wrap from DEPTH-1 to 0.
  - For DEPTH=1 the pointers are tied to 0 and the buffer acts as a classic pipeline latch.
- **Output and handshake signals:**
  - out_data = mem[rd_ptr], driven combinationally from the registered array.
  - out_data is 0 when count=0, so no stale data is exposed.
  - out_valid = (count != 0).
  - in_ready = (count != DEPTH). There is no combinational path from out_ready to in_ready, so a full buffer refuses a push even if a pop occurs in the same cycle.
- **Push / pop:**
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - On push: mem[wr_ptr] <= in_data and wr_ptr increments.
  - On pop: rd_ptr increments.
- **Count update:**
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - A simultaneous push and pop at count=1 is legal: the head advances to the new entry, which is visible the next cycle.
- **Latency:**
  - Minimum latency is 1 cycle: data pushed at edge N is on out_data with out_valid=1 after edge N.
  - Throughput is 1 bundle/cycle when DEPTH is 2 or more.
  - DEPTH=1 gives half throughput under continuous out_ready, because full blocks push. This is the intended behaviour.
- **Flush (sync, active-high):**
  - At the edge: count, rd_ptr and wr_ptr go to 0.
  - Flush overrides any push or pop in the same cycle; the pushed bundle is dropped.
  - Storage contents need not be cleared, but out_data reads 0 because count=0.
  - stall_cnt is not affected by flush.
- **stall_cnt:**
  - Increments on every edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- **Upstream protocol:**
  - The upstream may drop in_valid or change in_data without a completed push; nothing is captured unless push occurs.
  - The buffer itself holds out_data stable while out_valid=1 and out_ready=0.

Test Plan (DATA_W=8, DEPTH=2, CNT_W=4 unless noted):
- **Reset:** assert nRST low mid-run with count=2 -> immediately out_valid=0, count=0, in_ready=1, stall_cnt=0, out_data=8'h00.
- **Fill/drain:**
  - With out_ready=0, push 8'hA1 then 8'hB2 -> count=2, in_ready=0 and out_data=8'hA1.
  - A third in_valid with 8'hC3 is ignored.
  - Raise out_ready -> out_data shows A1 then B2, then out_valid=0.
- **Streaming with wrap:** in_valid=1 and out_ready=1 continuously for 8 cycles with data 8'h00..8'h07 -> out_data shows 00..07 one cycle after each push; count stays at 1; pointers wrap 4 times with no loss.
- **Flush:** with count=2, assert flush together with a push of 8'hEE -> next cycle count=0, out_valid=0; EE never appears on out_data.
- **Back-pressure saturation:** hold 1 entry with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); then flush -> stall_cnt remains 15.
- **DEPTH=1 variant:** continuous in_valid and out_ready with data 1,2,3 -> in_ready alternates 1/0 and outputs appear on alternate cycles in order 1,2,3.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_fifo
// Description : Elastic DEPTH-entry pipeline-stage buffer with valid/ready
//               handshake, synchronous flush, occupancy and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int                   C_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                   C_OCC_W     = $clog2(DEPTH+1);
   localparam logic [C_OCC_W-1:0]   C_FULL      = C_OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0]     C_STALL_MAX = '1;

   logic [C_OCC_W-1:0]      r_count;
   logic [CNT_W-1:0]        r_stall_cnt;
   logic [C_PTR_W-1:0]      w_rd_ptr;
   logic [C_PTR_W-1:0]      w_wr_ptr;
   logic [DEPTH*DATA_W-1:0] w_mem_flat;
   logic [DATA_W-1:0]       w_head;
   logic                    w_push;
   logic                    w_pop;

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = (r_count != C_FULL);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign count     = r_count;
   assign stall_cnt = r_stall_cnt;

   generate
      if (DEPTH > 1) begin : g_ptr
         logic [C_PTR_W-1:0] r_rd_ptr;
         logic [C_PTR_W-1:0] r_wr_ptr;

         // DEPTH is a power of two, so natural overflow is the wrap
         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
            end else if (flush) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
            end else begin
               if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
               if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
         end

         assign w_rd_ptr = r_rd_ptr;
         assign w_wr_ptr = r_wr_ptr;
      end else begin : g_ptr_tied
         assign w_rd_ptr = '0;
         assign w_wr_ptr = '0;
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [DATA_W-1:0] r_entry;

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               r_entry <= '0;
            end else if (w_push && !flush && (w_wr_ptr == C_PTR_W'(gi))) begin
               r_entry <= in_data;
            end
         end

         assign w_mem_flat[gi*DATA_W +: DATA_W] = r_entry;
      end
   endgenerate

   always_comb begin
      w_head = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_rd_ptr == C_PTR_W'(i)) w_head = w_mem_flat[i*DATA_W +: DATA_W];
      end
   end

   // Mask the head when empty so stale entries are never exposed
   assign out_data = out_valid ? w_head : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + C_OCC_W'(1);
      end else if (w_pop && !w_push) begin
         r_count <= r_count - C_OCC_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != C_STALL_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_fifo
// Description : Self-checking bench for pipe_stage_fifo (DEPTH=2 and DEPTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst;
   logic       a_flush, a_in_valid, a_out_ready, a_in_ready, a_out_valid;
   logic [7:0] a_in_data, a_out_data;
   logic [1:0] a_count;
   logic [3:0] a_stall;

   logic       b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
   logic [7:0] b_in_data, b_out_data;
   logic [0:0] b_count;
   logic [3:0] b_stall;

   pipe_stage_fifo #(.DATA_W(8), .DEPTH(2), .CNT_W(4)) dut_a (
      .CLK(clk), .nRST(nrst), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .count(a_count), .stall_cnt(a_stall));

   pipe_stage_fifo #(.DATA_W(8), .DEPTH(1), .CNT_W(4)) dut_b (
      .CLK(clk), .nRST(nrst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .count(b_count), .stall_cnt(b_stall));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: ordered queues plus saturating stall tallies
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int         sa, sb;

   task automatic model_reset();
      qa.delete();
      qb.delete();
      sa = 0;
      sb = 0;
   endtask

   function automatic logic [15:0] exp_a();
      int n = qa.size();
      return {n != 0, (n != 0) ? qa[0] : 8'h00, 2'(n), n != 2, 4'(sa)};
   endfunction

   function automatic logic [14:0] exp_b();
      int n = qb.size();
      return {n != 0, (n != 0) ? qb[0] : 8'h00, 1'(n), n != 1, 4'(sb)};
   endfunction

   // Advance one clock edge; inputs held since the previous tick are applied
   task automatic tick();
      bit av, ar, bv, br;
      av = (qa.size() != 0);
      ar = (qa.size() < 2);
      bv = (qb.size() != 0);
      br = (qb.size() < 1);
      @(posedge clk);
      if (av && !a_out_ready && sa < 15) sa++;
      if (bv && !b_out_ready && sb < 15) sb++;
      if (a_flush) qa.delete();
      else begin
         if (av && a_out_ready) void'(qa.pop_front());
         if (a_in_valid && ar)  qa.push_back(a_in_data);
      end
      if (b_flush) qb.delete();
      else begin
         if (bv && b_out_ready) void'(qb.pop_front());
         if (b_in_valid && br)  qb.push_back(b_in_data);
      end
      #1;
   endtask

   task automatic test_reset();
      n_tests++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready, a_stall} !== 16'h0010) begin
         n_fail++;
         $display("FAIL reset_init: got %h expected %h",
                  {a_out_valid, a_out_data, a_count, a_in_ready, a_stall}, 16'h0010);
      end
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 8'h5A;
      tick();
      a_in_data   = 8'h6B;
      tick();
      a_in_valid  = 1'b0;
      n_tests++;
      if (a_count !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_prefill_count: got %0d expected 2", a_count);
      end
      #2 nrst = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready, a_stall} !== 16'h0010) begin
         n_fail++;
         $display("FAIL reset_midrun: got %h expected %h",
                  {a_out_valid, a_out_data, a_count, a_in_ready, a_stall}, 16'h0010);
      end
      nrst = 1'b1;
   endtask

   task automatic test_fill_drain();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 8'hA1;
      tick();
      a_in_data   = 8'hB2;
      tick();
      n_tests++;
      if ({a_count, a_in_ready, a_out_data} !== {2'd2, 1'b0, 8'hA1}) begin
         n_fail++;
         $display("FAIL fill_full: got cnt=%0d rdy=%b data=%h expected cnt=2 rdy=0 data=a1",
                  a_count, a_in_ready, a_out_data);
      end
      a_in_data = 8'hC3;
      tick();
      a_in_valid = 1'b0;
      n_tests++;
      if ({a_count, a_out_data} !== {2'd2, 8'hA1}) begin
         n_fail++;
         $display("FAIL fill_ignore_third: got cnt=%0d data=%h expected cnt=2 data=a1",
                  a_count, a_out_data);
      end
      a_out_ready = 1'b1;
      tick();
      n_tests++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'hB2}) begin
         n_fail++;
         $display("FAIL drain_second: got v=%b data=%h expected v=1 data=b2",
                  a_out_valid, a_out_data);
      end
      tick();
      n_tests++;
      if ({a_out_valid, a_out_data, a_count} !== {1'b0, 8'h00, 2'd0}) begin
         n_fail++;
         $display("FAIL drain_empty: got v=%b data=%h cnt=%0d expected v=0 data=00 cnt=0",
                  a_out_valid, a_out_data, a_count);
      end
   endtask

   task automatic test_stream();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_in_data = 8'(i);
         tick();
         n_tests++;
         if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b1, 8'(i), 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_%0d: got v=%b data=%h cnt=%0d rdy=%b expected v=1 data=%h cnt=1 rdy=1",
                     i, a_out_valid, a_out_data, a_count, a_in_ready, 8'(i));
         end
      end
      a_in_valid = 1'b0;
      tick();
      n_tests++;
      if (a_count !== 2'd0) begin
         n_fail++;
         $display("FAIL stream_drain: got cnt=%0d expected 0", a_count);
      end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 8'h11;
      tick();
      a_in_data   = 8'h22;
      tick();
      a_flush     = 1'b1;
      a_in_data   = 8'hEE;
      tick();
      a_flush     = 1'b0;
      a_in_valid  = 1'b0;
      n_tests++;
      if ({a_out_valid, a_count, a_out_data} !== {1'b0, 2'd0, 8'h00}) begin
         n_fail++;
         $display("FAIL flush_clear: got v=%b cnt=%0d data=%h expected v=0 cnt=0 data=00",
                  a_out_valid, a_count, a_out_data);
      end
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (a_out_valid !== 1'b0 || a_out_data === 8'hEE) begin
            n_fail++;
            $display("FAIL flush_no_ee_%0d: got v=%b data=%h expected v=0 data=00",
                     i, a_out_valid, a_out_data);
         end
      end
   endtask

   task automatic test_saturation();
      #2 nrst = 1'b0;
      #1 nrst = 1'b1;
      model_reset();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 8'h3C;
      tick();
      a_in_valid  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         n_tests++;
         if ({a_stall, a_out_data} !== {4'((i > 15) ? 15 : i), 8'h3C}) begin
            n_fail++;
            $display("FAIL stall_cycle_%0d: got stall=%0d data=%h expected stall=%0d data=3c",
                     i, a_stall, a_out_data, (i > 15) ? 15 : i);
         end
      end
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      n_tests++;
      if ({a_stall, a_count} !== {4'd15, 2'd0}) begin
         n_fail++;
         $display("FAIL stall_after_flush: got stall=%0d cnt=%0d expected stall=15 cnt=0",
                  a_stall, a_count);
      end
   endtask

   task automatic test_depth1();
      b_out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         n_tests++;
         if (b_in_ready !== ((k % 2) == 0)) begin
            n_fail++;
            $display("FAIL d1_ready_%0d: got %b expected %b", k, b_in_ready, (k % 2) == 0);
         end
         n_tests++;
         if (b_out_valid !== ((k % 2) == 1) ||
             ((k % 2) == 1 && b_out_data !== 8'((k + 1) / 2))) begin
            n_fail++;
            $display("FAIL d1_out_%0d: got v=%b data=%h expected v=%b data=%h",
                     k, b_out_valid, b_out_data, (k % 2) == 1, 8'((k + 1) / 2));
         end
         b_in_valid = (k < 5);
         b_in_data  = 8'(k / 2 + 1);
         tick();
      end
      b_in_valid = 1'b0;
      n_tests++;
      if (b_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL d1_done: got v=%b expected 0", b_out_valid);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         a_flush     = ($urandom_range(15) == 0);
         a_in_valid  = 1'($urandom_range(1));
         a_in_data   = 8'($urandom);
         a_out_ready = ($urandom_range(3) != 0);
         b_flush     = ($urandom_range(15) == 0);
         b_in_valid  = 1'($urandom_range(1));
         b_in_data   = 8'($urandom);
         b_out_ready = ($urandom_range(2) != 0);
         tick();
         n_tests++;
         if ({a_out_valid, a_out_data, a_count, a_in_ready, a_stall} !== exp_a()) begin
            n_fail++;
            $display("FAIL rand_a_%0d: got %h expected %h", c,
                     {a_out_valid, a_out_data, a_count, a_in_ready, a_stall}, exp_a());
         end
         n_tests++;
         if ({b_out_valid, b_out_data, b_count, b_in_ready, b_stall} !== exp_b()) begin
            n_fail++;
            $display("FAIL rand_b_%0d: got %h expected %h", c,
                     {b_out_valid, b_out_data, b_count, b_in_ready, b_stall}, exp_b());
         end
      end
      a_flush = 1'b0;
      b_flush = 1'b0;
   endtask

   initial begin
      nrst        = 1'b0;
      a_flush     = 1'b0;
      a_in_valid  = 1'b0;
      a_in_data   = 8'h00;
      a_out_ready = 1'b0;
      b_flush     = 1'b0;
      b_in_valid  = 1'b0;
      b_in_data   = 8'h00;
      b_out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;

      test_reset();
      test_fill_drain();
      test_stream();
      test_flush();
      test_saturation();
      test_depth1();
      test_random();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
